// File: rtl/xalu_conf_seq.sv
// Configuration sequencer for one xalu: a small table of configdata words with
// repeat counts, replayed onto configdata after a run command, optionally looping.
module xalu_conf_seq #(
    parameter int N_W       = 5,
    parameter int ALU_FNS_W = 4,
    parameter int CONF_W    = 2*N_W + ALU_FNS_W,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 8,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_req,
    input  logic              ctrl_rnw,
    input  logic [ADDR_W-1:0] ctrl_addr,
    input  logic [DATA_W-1:0] ctrl_data_to_wr,
    output logic [DATA_W-1:0] ctrl_data_to_rd,
    input  logic              hold,
    output logic [CONF_W-1:0] configdata,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W     = $clog2(DEPTH);
    localparam int LOOP_BIT  = 8;
    localparam int RUN_BIT   = 29;
    localparam int ABORT_BIT = 30;
    localparam int BUSY_BIT  = 31;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CONF_W-1:0] conf_q [DEPTH];
    logic [CONF_W-1:0] conf_d [DEPTH];
    logic [CNT_W-1:0]  rep_q  [DEPTH];
    logic [CNT_W-1:0]  rep_d  [DEPTH];
    logic [IDX_W-1:0]  last_q, last_d;
    logic              loop_q, loop_d;
    logic              run_q, run_d;
    logic              abort_q, abort_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CONF_W-1:0] configdata_q, configdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic              wr_s, rd_s, tbl_hit_s, ctrl_hit_s;
    logic [IDX_W-1:0]  tbl_idx_s, nxt_idx_s;
    logic              unused_s;

    assign wr_s       = ctrl_req & ~ctrl_rnw;
    assign rd_s       = ctrl_req & ctrl_rnw;
    assign tbl_hit_s  = (ctrl_addr < CTRL_ADDR);
    assign ctrl_hit_s = (ctrl_addr == CTRL_ADDR);
    assign tbl_idx_s  = ctrl_addr[IDX_W-1:0];
    assign nxt_idx_s  = idx_q + IDX_W'(1);
    assign unused_s   = ^ctrl_data_to_wr;

    // Table writes; accepted in any state, a load at the same edge sees the old entry
    always_comb begin
        conf_d = conf_q;
        rep_d  = rep_q;
        if (wr_s && tbl_hit_s) begin
            conf_d[tbl_idx_s] = ctrl_data_to_wr[CONF_W-1:0];
            rep_d[tbl_idx_s]  = ctrl_data_to_wr[DATA_W-1 -: CNT_W];
        end else begin
            conf_d = conf_q;
            rep_d  = rep_q;
        end
    end

    // Control register writes; only abort is honoured while a sequence is active
    always_comb begin
        last_d  = last_q;
        loop_d  = loop_q;
        run_d   = 1'b0;
        abort_d = 1'b0;
        if (wr_s && ctrl_hit_s) begin
            if (busy_q) begin
                abort_d = ctrl_data_to_wr[ABORT_BIT];
            end else begin
                last_d = ctrl_data_to_wr[IDX_W-1:0];
                loop_d = ctrl_data_to_wr[LOOP_BIT];
                run_d  = ctrl_data_to_wr[RUN_BIT];
            end
        end else begin
            run_d   = 1'b0;
            abort_d = 1'b0;
        end
    end

    // Sequencer next state: entry load, repeat countdown, hold, loop and abort
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        configdata_d = configdata_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_q) begin
                    state_d      = S_RUN;
                    idx_d        = IDX_W'(0);
                    cnt_d        = rep_q[0];
                    configdata_d = conf_q[0];
                    busy_d       = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_RUN: begin
                if (abort_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (hold) begin
                    busy_d = 1'b1;
                end else if (cnt_q != CNT_W'(0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q != last_q) begin
                    idx_d        = nxt_idx_s;
                    cnt_d        = rep_q[nxt_idx_s];
                    configdata_d = conf_q[nxt_idx_s];
                end else if (loop_q) begin
                    idx_d        = IDX_W'(0);
                    cnt_d        = rep_q[0];
                    configdata_d = conf_q[0];
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Read data capture; unmapped bits and unmapped addresses read as zero
    always_comb begin
        rd_d = rd_q;
        if (rd_s) begin
            rd_d = '0;
            if (tbl_hit_s) begin
                rd_d[DATA_W-1 -: CNT_W] = rep_q[tbl_idx_s];
                rd_d[CONF_W-1:0]        = conf_q[tbl_idx_s];
            end else if (ctrl_hit_s) begin
                rd_d[IDX_W-1:0] = last_q;
                rd_d[LOOP_BIT]  = loop_q;
                rd_d[BUSY_BIT]  = busy_q;
            end else begin
                rd_d = '0;
            end
        end else begin
            rd_d = rd_q;
        end
    end

    // Table storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                conf_q[i] <= '0;
                rep_q[i]  <= '0;
            end
        end else begin
            conf_q <= conf_d;
            rep_q  <= rep_d;
        end
    end

    // Control, sequencer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_q       <= '0;
            loop_q       <= 1'b0;
            run_q        <= 1'b0;
            abort_q      <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            configdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            loop_q       <= loop_d;
            run_q        <= run_d;
            abort_q      <= abort_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            configdata_q <= configdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_q         <= rd_d;
        end
    end

    assign configdata      = configdata_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign ctrl_data_to_rd = rd_q;

endmodule

// File: tb/tb_xalu_conf_seq.sv
// Directed bench for xalu_conf_seq with a small downstream ALU consumer.
module tb_xalu_conf_seq;

    localparam logic [3:0]  CTRL = 4'd8;
    localparam logic [13:0] E0   = 14'h0640;  // sa=3 sb=4 fns=ADD, rep=2
    localparam logic [13:0] E1   = 14'h0831;  // sa=4 sb=3 fns=SUB, rep=0
    localparam logic [13:0] E1B  = 14'h0A62;
    localparam logic [13:0] E0B  = 14'h1ABC;
    localparam logic [31:0] W0   = 32'h0200_0640;
    localparam logic [31:0] W1   = 32'h0000_0831;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_req;
    logic        ctrl_rnw;
    logic [3:0]  ctrl_addr;
    logic [31:0] ctrl_data_to_wr;
    logic [31:0] ctrl_data_to_rd;
    logic        hold;
    logic [13:0] configdata;
    logic        busy;
    logic        done;
    logic [31:0] alu_result;
    int          n_pass = 0;
    int          n_total = 0;

    xalu_conf_seq dut (
        .clk(clk), .rst(rst), .ctrl_req(ctrl_req), .ctrl_rnw(ctrl_rnw),
        .ctrl_addr(ctrl_addr), .ctrl_data_to_wr(ctrl_data_to_wr),
        .ctrl_data_to_rd(ctrl_data_to_rd), .hold(hold),
        .configdata(configdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Downstream ALU: bus slot 3 holds 25, slot 4 holds 26; fns 0 = ADD, 1 = SUB
    function automatic logic [31:0] bus_slot(input logic [4:0] s);
        if (s == 5'd3) return 32'd25;
        else if (s == 5'd4) return 32'd26;
        else return 32'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (configdata[3:0] == 4'd0)
            alu_result <= bus_slot(configdata[13:9]) + bus_slot(configdata[8:4]);
        else if (configdata[3:0] == 4'd1)
            alu_result <= bus_slot(configdata[13:9]) - bus_slot(configdata[8:4]);
        else
            alu_result <= 32'd0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        ctrl_req = 1'b1; ctrl_rnw = 1'b0; ctrl_addr = a; ctrl_data_to_wr = d;
        tick();
        ctrl_req = 1'b0; ctrl_data_to_wr = 32'd0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        ctrl_req = 1'b1; ctrl_rnw = 1'b1; ctrl_addr = a;
        tick();
        ctrl_req = 1'b0; ctrl_rnw = 1'b0;
        d = ctrl_data_to_rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; ctrl_req = 1'b0; ctrl_rnw = 1'b0;
        ctrl_addr = 4'd0; ctrl_data_to_wr = 32'd0;
        repeat (3) tick();
        n_total++;
        if ({configdata, busy, done, ctrl_data_to_rd} !== 48'd0)
            $display("FAIL reset_outputs: got conf=%h busy=%b done=%b rd=%h expected all 0", configdata, busy, done, ctrl_data_to_rd);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if (busy !== 1'b0 || configdata !== 14'd0)
            $display("FAIL reset_idle: got busy=%b conf=%h expected 0/0", busy, configdata);
        else n_pass++;
    endtask

    task automatic test_two_entry();
        logic [13:0] ce;
        wr(4'd0, W0);
        wr(4'd1, W1);
        wr(CTRL, 32'h2000_0001);
        for (int k = 1; k <= 6; k++) begin
            tick();
            ce = (k <= 3) ? E0 : E1;
            n_total++;
            if (configdata !== ce) $display("FAIL two_conf k=%0d: got %h expected %h", k, configdata, ce);
            else n_pass++;
            n_total++;
            if (busy !== (k <= 4)) $display("FAIL two_busy k=%0d: got %b expected %b", k, busy, (k <= 4));
            else n_pass++;
            n_total++;
            if (done !== (k == 5)) $display("FAIL two_done k=%0d: got %b expected %b", k, done, (k == 5));
            else n_pass++;
            if (k == 2) begin
                n_total++;
                if (alu_result !== 32'd51) $display("FAIL alu_add: got %0d expected 51", alu_result);
                else n_pass++;
            end
            if (k == 5) begin
                n_total++;
                if (alu_result !== 32'd1) $display("FAIL alu_sub: got %0d expected 1", alu_result);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hold();
        logic [13:0] ce;
        wr(CTRL, 32'h2000_0001);
        for (int k = 1; k <= 8; k++) begin
            tick();
            ce = (k <= 5) ? E0 : E1;
            n_total++;
            if (configdata !== ce) $display("FAIL hold_conf k=%0d: got %h expected %h", k, configdata, ce);
            else n_pass++;
            n_total++;
            if (busy !== (k <= 6)) $display("FAIL hold_busy k=%0d: got %b expected %b", k, busy, (k <= 6));
            else n_pass++;
            n_total++;
            if (done !== (k == 7)) $display("FAIL hold_done k=%0d: got %b expected %b", k, done, (k == 7));
            else n_pass++;
            hold = (k == 1 || k == 2);
        end
        hold = 1'b0;
    endtask

    task automatic test_loop_abort();
        logic [13:0] ce;
        logic [31:0] d;
        wr(CTRL, 32'h2000_0101);
        for (int k = 1; k <= 20; k++) begin
            tick();
            ce = (((k - 1) % 4) < 3) ? E0 : E1;
            n_total++;
            if (configdata !== ce || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL loop_k%0d: got conf=%h busy=%b done=%b expected %h/1/0", k, configdata, busy, done, ce);
            else n_pass++;
        end
        wr(CTRL, 32'h4000_0000);
        n_total++;
        if (busy !== 1'b1 || configdata !== E0)
            $display("FAIL abort_edge: got busy=%b conf=%h expected 1/%h", busy, configdata, E0);
        else n_pass++;
        tick();
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || configdata !== E0)
            $display("FAIL abort_idle: got busy=%b done=%b conf=%h expected 0/0/%h", busy, done, configdata, E0);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_nodone: got done=%b busy=%b expected 0/0", done, busy);
        else n_pass++;
        rd(CTRL, d);
        n_total++;
        if (d !== 32'h0000_0101) $display("FAIL ctrl_read_idle: got %h expected 00000101", d);
        else n_pass++;
    endtask

    task automatic test_readback();
        logic [31:0] d;
        wr(4'd2, 32'hFF00_1234);
        rd(4'd2, d);
        n_total++;
        if (d !== 32'hFF00_1234) $display("FAIL read_e2: got %h expected ff001234", d);
        else n_pass++;
        wr(4'd5, 32'hFFFF_FFFF);
        rd(4'd5, d);
        n_total++;
        if (d !== 32'hFF00_3FFF) $display("FAIL read_mask: got %h expected ff003fff", d);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (ctrl_data_to_rd !== 32'hFF00_3FFF) $display("FAIL read_hold: got %h expected ff003fff", ctrl_data_to_rd);
        else n_pass++;
    endtask

    task automatic test_busy_writes();
        logic [31:0] d;
        wr(CTRL, 32'h2000_0101);
        tick();
        rd(CTRL, d);
        n_total++;
        if (d !== 32'h8000_0101) $display("FAIL ctrl_read_busy: got %h expected 80000101", d);
        else n_pass++;
        wr(CTRL, 32'h2000_0000);
        n_total++;
        if (configdata !== E0) $display("FAIL busy_run_a: got %h expected %h", configdata, E0);
        else n_pass++;
        tick();
        n_total++;
        if (configdata !== E1 || busy !== 1'b1) $display("FAIL busy_run_b: got %h busy=%b expected %h/1", configdata, busy, E1);
        else n_pass++;
        tick();
        rd(CTRL, d);
        n_total++;
        if (d !== 32'h8000_0101) $display("FAIL ctrl_unchanged: got %h expected 80000101", d);
        else n_pass++;
        wr(4'd1, {18'd0, E1B});
        n_total++;
        if (configdata !== E0) $display("FAIL tblwr_a: got %h expected %h", configdata, E0);
        else n_pass++;
        tick();
        n_total++;
        if (configdata !== E1B) $display("FAIL tblwr_new: got %h expected %h", configdata, E1B);
        else n_pass++;
        wr(4'd0, {18'd0, E0B});
        n_total++;
        if (configdata !== E0) $display("FAIL tblwr_coincide: got %h expected %h", configdata, E0);
        else n_pass++;
        tick(); tick(); tick();
        n_total++;
        if (configdata !== E1B) $display("FAIL tblwr_c: got %h expected %h", configdata, E1B);
        else n_pass++;
        tick();
        n_total++;
        if (configdata !== E0B) $display("FAIL tblwr_e0b: got %h expected %h", configdata, E0B);
        else n_pass++;
        wr(CTRL, 32'h4000_0000);
        tick();
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || configdata !== E1B)
            $display("FAIL busy_abort: got busy=%b done=%b conf=%h expected 0/0/%h", busy, done, configdata, E1B);
        else n_pass++;
    endtask

    task automatic test_mid_run_reset();
        logic [31:0] d;
        wr(4'd3, 32'h1200_0555);
        wr(4'd0, W0);
        wr(CTRL, 32'h2000_0101);
        tick();
        rd(4'd3, d);
        n_total++;
        if (d !== 32'h1200_0555) $display("FAIL read_e3: got %h expected 12000555", d);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({configdata, busy, done, ctrl_data_to_rd} !== 48'd0)
            $display("FAIL async_reset: got conf=%h busy=%b done=%b rd=%h expected all 0", configdata, busy, done, ctrl_data_to_rd);
        else n_pass++;
        tick();
        rst = 1'b0;
        rd(4'd3, d);
        n_total++;
        if (d !== 32'd0) $display("FAIL reset_table: got %h expected 00000000", d);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (busy !== 1'b0 || configdata !== 14'd0) $display("FAIL reset_stays_idle: got busy=%b conf=%h expected 0/0", busy, configdata);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_two_entry();
        test_hold();
        test_loop_abort();
        test_readback();
        test_busy_writes();
        test_mid_run_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
